// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the P7 stall/flush controller: MDU sequencer state
// encodings, the "not used" timing value, default MDU latencies and the hazard term.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MULT = 2'd1,
      MD_DIV  = 2'd2
   } md_state_e;

   localparam logic [1:0] T_UNUSED        = 2'd3;
   localparam int         MULT_CYCLES_DEF = 5;
   localparam int         DIV_CYCLES_DEF  = 10;

   // One producer/consumer pair: fires when D needs the value before it is ready.
   function automatic logic src_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] dst,
      input logic       we,
      input logic [1:0] tnew
   );
      return we && (dst != 5'd0) && (src == dst) && (tuse != T_UNUSED) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_seq.sv
// Mult/div occupancy sequencer: tracks which operation owns HI/LO and counts
// down its latency; busy is decoded straight from the state register.
module md_busy_seq
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   input  logic req,
   output logic busy
);

   md_state_e         state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= MD_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         MD_IDLE: begin
            // A start alongside Req belongs to a cancelled instruction.
            if (start && !req) begin
               state_next = is_div ? MD_DIV : MD_MULT;
               cnt_next   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end
         end
         default: begin
            // Starts seen while busy are ignored; the count is never reloaded.
            if (cnt_reg <= CNT_W'(1)) begin
               state_next = MD_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
      endcase
   end

   assign busy = (state_reg != MD_IDLE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage P7 pipeline.
// Optional STALL_PERF_CNT_EN adds free-running Stall/Flush event counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic [1:0]  D_Tuse_rs,
   input  logic [1:0]  D_Tuse_rt,
   input  logic [4:0]  E_RegAddr,
   input  logic [4:0]  M_RegAddr,
   input  logic        E_RegWrite,
   input  logic        M_RegWrite,
   input  logic [1:0]  E_Tnew,
   input  logic [1:0]  M_Tnew,
   input  logic        D_IsMD,
   input  logic        E_MDStart,
   input  logic        E_MDIsDiv,
   input  logic        Req,
   output logic        Stall,
   output logic        Flush,
   output logic        MD_Busy
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0] Stall_Cnt,
   output logic [31:0] Flush_Cnt
`endif
);

   logic [4:0] src  [2];
   logic [1:0] tuse [2];
   logic [1:0] hz_e, hz_m;
   logic       md_stall;

   assign src[0]  = D_rs;
   assign src[1]  = D_rt;
   assign tuse[0] = D_Tuse_rs;
   assign tuse[1] = D_Tuse_rt;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign hz_e[gi] = src_hazard(src[gi], tuse[gi], E_RegAddr, E_RegWrite, E_Tnew);
         assign hz_m[gi] = src_hazard(src[gi], tuse[gi], M_RegAddr, M_RegWrite, M_Tnew);
      end
   endgenerate

   md_busy_seq #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_busy_seq (
      .clk    (clk),
      .reset  (reset),
      .start  (E_MDStart),
      .is_div (E_MDIsDiv),
      .req    (Req),
      .busy   (MD_Busy)
   );

   // E_MDStart counts as busy already: the MDU is claimed at the next edge.
   assign md_stall = D_IsMD && (MD_Busy || E_MDStart);

   // Both outputs are forced low while reset is held; Flush wins over Stall.
   assign Stall = reset && !Req && ((|hz_e) || (|hz_m) || md_stall);
   assign Flush = reset && Req;

`ifdef STALL_PERF_CNT_EN
   logic [31:0] stall_cnt_reg, flush_cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (Stall) stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if (Flush) flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
   end

   assign Stall_Cnt = stall_cnt_reg;
   assign Flush_Cnt = flush_cnt_reg;
`else
   // Counters absent: the controller is purely hazard compare plus MDU sequencer.
`endif

endmodule
